// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - 128x8 single-port RAM with a request/ready handshake and fixed access latency
// Optional: BYTE_RAM_CLEAR_ON_RESET_EN zeroes the array on reset.
module byte_ram #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] input_data,
  output logic [DATA_W-1:0] output_data,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready       <= 1'b0;
      output_data <= '0;
      cnt         <= '0;
`ifdef BYTE_RAM_CLEAR_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          // Only a request naming exactly one operation is accepted.
          if (en && (read ^ write)) begin
            op_write <= write;
            addr_q   <= address;
            data_q   <= input_data;
            cnt      <= CNT_W'(LATENCY - 1);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!en) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            if (op_write) mem[addr_q] <= data_q;
            else          output_data <= mem[addr_q];
            ready <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_ram.sv
// tb/tb_byte_ram.sv - self-checking bench for byte_ram against an array reference model
module tb_byte_ram;

  localparam int LATENCY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic [6:0] address = '0;
  logic [7:0] input_data = '0;
  logic [7:0] output_data;
  logic       ready;

  byte_ram #(.ADDR_W(7), .DATA_W(8), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .en(en), .read(read), .write(write),
    .address(address), .input_data(input_data),
    .output_data(output_data), .ready(ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  logic [7:0] model [128];
  bit         known [128];
  logic [7:0] exp_out = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic access(input bit wr, input logic [6:0] a, input logic [7:0] d);
    int n;
    bit got;
    @(negedge clk);
    en = 1'b1; read = !wr; write = wr; address = a; input_data = d;
    n = 99; got = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (ready) begin got = 1; n = i; end
    end
    en = 1'b0; read = 1'b0; write = 1'b0;
    // Accept edge is the first edge, completion LATENCY edges later.
    check(wr ? "wr_latency" : "rd_latency", n, LATENCY + 1);
    if (wr) begin
      model[a] = d; known[a] = 1;
    end else begin
      exp_out = model[a];
      check("rd_data", output_data, exp_out);
    end
    @(posedge clk); #1;
    check("ready_one_cycle", ready, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) known[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready, 1'b0);
    check("reset_out", output_data, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Write then read
    access(1, 7'd5, 8'hA7);
    access(0, 7'd5, 8'h00);

    // Held read request pulses every LATENCY+2 cycles
    @(negedge clk); en = 1'b1; read = 1'b1; address = 7'd5;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      check("held_ready", ready, (i % 4 == 3) ? 1'b1 : 1'b0);
      check("held_data", output_data, 8'hA7);
    end
    en = 1'b0; read = 1'b0;
    @(posedge clk); #1;

    // Abort a write by dropping en
    access(1, 7'd9, 8'h55);
    @(negedge clk); en = 1'b1; write = 1'b1; address = 7'd9; input_data = 8'h3C;
    @(posedge clk); #1;
    en = 1'b0; write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_ready", ready, 1'b0);
    end
    access(0, 7'd9, 8'h00);

    // Illegal read+write request is ignored
    @(negedge clk); en = 1'b1; read = 1'b1; write = 1'b1; address = 7'd5; input_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("illegal_ready", ready, 1'b0);
      check("illegal_out", output_data, exp_out);
    end
    en = 1'b0; read = 1'b0; write = 1'b0;
    access(0, 7'd5, 8'h00);

    // Reset in the middle of a read
    @(negedge clk); en = 1'b1; read = 1'b1; address = 7'd5;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", ready, 1'b0);
    check("rst_mid_out", output_data, 8'h00);
    reset = 1'b0; en = 1'b0; read = 1'b0;
    exp_out = 8'h00;
`ifdef BYTE_RAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 128; i++) begin model[i] = 8'h00; known[i] = 1; end
`endif
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_after_ready", ready, 1'b0);
      check("rst_after_out", output_data, 8'h00);
    end
`ifdef BYTE_RAM_CLEAR_ON_RESET_EN
    access(0, 7'd9, 8'h00);
`endif

    // Address boundaries
    access(1, 7'd127, 8'hFF);
    access(1, 7'd0, 8'h01);
    access(0, 7'd127, 8'h00);
    access(0, 7'd0, 8'h00);

    // Randomised traffic against the model
    for (int i = 0; i < 30; i++) begin
      logic [6:0] a;
      bit wr;
      a  = 7'($urandom_range(0, 127));
      wr = $urandom_range(0, 1) == 1 || !known[a];
      access(wr, a, 8'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/byte_ram.md
Name: byte_ram

Overview:
- Single-port 128 x 8 synchronous RAM with a request/ready handshake.
- Serves as the backing store behind the four-client memory controller, which holds one request stable until ready is seen.
- Access latency is fixed and parameterised, so the controller can model slow memory.

Parameters:
- ADDR_W, 7, address width; depth is 2**ADDR_W words.
- DATA_W, 8, data word width.
- LATENCY, 2, clock edges from request acceptance to ready; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  request enable; deasserting it aborts an in-flight access.
- read  in  1  read request; valid only when write=0.
- write  in  1  write request; valid only when read=0.
- address  in  ADDR_W  word address.
- input_data  in  DATA_W  write data.
- output_data  out  DATA_W  registered read data; holds its value between reads.
- ready  out  1  one-cycle pulse marking access completion.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (sampled at a clk edge):
  - state goes to IDLE, ready=0, output_data=0, latency counter=0.
  - Any in-flight access is discarded and no write is committed.
- IDLE:
  - Acceptance condition at an edge: en=1 and exactly one of read or write is 1.
  - On acceptance: latch op, address and input_data; load counter with LATENCY-1; go to BUSY.
  - en=1 with read=write=0 or read=write=1: ignored, stay IDLE, ready=0.
- BUSY:
  - Counter decrements each edge. Request inputs other than en are not resampled; only the latched copies are used.
- Completion: the request is accepted at edge k and completes at edge k+LATENCY.
  - Write: mem[addr] <= data.
  - Read: output_data <= mem[addr].
  - ready=1 for exactly the cycle after edge k+LATENCY; FSM is in DONE during that cycle.
- Read-during-write: not applicable, since the block is single-port with one access at a time.
- Abort: en=0 at any BUSY edge returns to IDLE.
  - No write, output_data unchanged, ready stays 0.
- DONE:
  - Always returns to IDLE at the next edge, with ready=0.
  - A request held asserted is re-accepted at the edge after that, giving a one idle cycle turnaround.
  - Back-to-back accesses therefore cost LATENCY+2 cycles each.
- LATENCY=1: BUSY lasts zero edges; acceptance goes straight to completion at edge k+1.
- Address wraps naturally within ADDR_W bits; there is no out-of-range case.
- Array contents are not reset (see Optional Feature).
- ready is registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: BYTE_RAM_CLEAR_ON_RESET_EN.
- Defined: reset additionally zeroes every array location in the same edge; reads after reset return 0.
- Undefined: reset affects only FSM, counter, ready and output_data; array contents are preserved across reset and power up undefined (X in simulation).

Test Plan (LATENCY=2):
- Write then read: en=1, write=1, address=5, input_data=0xA7 accepted at edge 0 -> ready high after edge 2 only. Then read address 5 -> output_data=0xA7 with ready one cycle.
- Held request: keep read=1, address=5 asserted continuously -> ready pulses every 4 cycles; output_data stays 0xA7.
- Abort: start write 0x3C to address 9, drop en at edge 1 -> no ready pulse; a subsequent read of address 9 returns the old value.
- Illegal op: en=1, read=1, write=1 for 5 cycles -> ready never asserts, memory unchanged, output_data unchanged.
- Reset mid-read: assert reset at edge 1 of a read -> ready=0 and output_data=0 after that edge; no completion pulse.
- Wrap/boundary: write 0xFF to address 127 and 0x01 to address 0, read both back -> 0xFF and 0x01. With BYTE_RAM_CLEAR_ON_RESET_EN, read any address after reset -> 0x00.
